// File: rtl/calculation_add.sv
// calculation_add: multi-cycle 32-bit adder, one 8-bit slice per cycle, with per-bit carry vector and signed overflow.
// Define ADD_ACCUM_EN to replace inputY with an internal accumulator (cleared by clr_acc, loaded on done).
module calculation_add (
    input  logic        add_clk,
    input  logic        add_rst_n,
    input  logic        start,
    input  logic [31:0] inputX,
    input  logic [31:0] inputY,
    input  logic        cin,
`ifdef ADD_ACCUM_EN
    input  logic        clr_acc,
`endif
    output logic        busy,
    output logic        done,
    output logic [31:0] sum,
    output logic [31:0] cout,
    output logic        overflow
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t      state_q, state_d;
    logic [1:0]  k_q, k_d;
    logic [31:0] x_q, x_d, y_q, y_d;
    logic        c_q, c_d;
    logic [31:0] sum_q, sum_d, cout_q, cout_d;
    logic        ovf_q, ovf_d;
    logic [31:0] y_src;
    logic        accept;
    logic [7:0]  xs, ys, ss, cs;
    logic        c;
`ifdef ADD_ACCUM_EN
    logic [31:0] acc_q, acc_d;
    logic        unused_y;
    assign unused_y = ^inputY;
    // a load on done is forwarded so a back-to-back start sees the fresh accumulator
    assign acc_d = (clr_acc && state_q != CALC) ? 32'd0 : (state_q == DONE) ? sum_q : acc_q;
    assign y_src = acc_d;
`else
    assign y_src = inputY;
`endif
    assign accept = start && state_q != CALC;
    always_comb begin
        xs = x_q[{k_q, 3'b000} +: 8];
        ys = y_q[{k_q, 3'b000} +: 8];
        c  = (k_q == 2'd0) ? c_q : cout_q[{k_q, 3'b000} - 5'd1];
        ss = 8'd0;
        cs = 8'd0;
        for (int i = 0; i < 8; i++) begin
            ss[i] = xs[i] ^ ys[i] ^ c;
            c     = (xs[i] & ys[i]) | ((xs[i] ^ ys[i]) & c);
            cs[i] = c;
        end
    end
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        x_d     = x_q;
        y_d     = y_q;
        c_d     = c_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (accept) begin
            state_d = CALC;
            k_d     = 2'd0;
            x_d     = inputX;
            y_d     = y_src;
            c_d     = cin;
            sum_d   = 32'd0;
            cout_d  = 32'd0;
            ovf_d   = 1'b0;
        end else if (state_q == CALC) begin
            sum_d[{k_q, 3'b000} +: 8]  = ss;
            cout_d[{k_q, 3'b000} +: 8] = cs;
            ovf_d   = (k_q == 2'd3) ? cs[7] ^ cs[6] : ovf_q;
            k_d     = k_q + 2'd1;
            state_d = (k_q == 2'd3) ? DONE : CALC;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge add_clk) begin
        if (!add_rst_n) begin
            state_q <= IDLE;
            k_q     <= 2'd0;
            x_q     <= 32'd0;
            y_q     <= 32'd0;
            c_q     <= 1'b0;
            sum_q   <= 32'd0;
            cout_q  <= 32'd0;
            ovf_q   <= 1'b0;
`ifdef ADD_ACCUM_EN
            acc_q   <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            x_q     <= x_d;
            y_q     <= y_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
`ifdef ADD_ACCUM_EN
            acc_q   <= acc_d;
`endif
        end
    end
    assign busy     = state_q == CALC;
    assign done     = state_q == DONE;
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_calculation_add.sv
// tb_calculation_add: vector table, corner sequences and random ops against an arithmetic reference model.
module tb_calculation_add;
    logic        add_clk = 1'b0;
    logic        add_rst_n, start, cin, clr_acc;
    logic [31:0] inputX, inputY;
    logic        busy, done, overflow;
    logic [31:0] sum, cout;
    int          pass_cnt = 0, total_cnt = 0;

    calculation_add dut (
        .add_clk(add_clk), .add_rst_n(add_rst_n), .start(start),
        .inputX(inputX), .inputY(inputY), .cin(cin),
`ifdef ADD_ACCUM_EN
        .clr_acc(clr_acc),
`endif
        .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
    );

    always #5 add_clk = ~add_clk;

    typedef struct {
        logic [31:0] x, y;
        logic        c;
        logic [31:0] s, co;
        logic        ov;
    } vec_t;

    task automatic tick();
        @(posedge add_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // carry out of bit i is bit i+1 of the sum of the low i+1 bits
    task automatic ref_add(input logic [31:0] x, input logic [31:0] y, input logic c,
                           output logic [31:0] s, output logic [31:0] co, output logic ov);
        longint t, r;
        s = x + y + 32'(c);
        for (int i = 0; i < 32; i++) begin
            t = (longint'(x) & ((64'd1 << (i + 1)) - 1)) + (longint'(y) & ((64'd1 << (i + 1)) - 1)) + longint'(c);
            co[i] = t[i + 1];
        end
        r  = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
        ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endtask

    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic c);
        int n = 0, b = 0;
        inputX = x; inputY = y; cin = c; start = 1'b1;
        tick();
        start = 1'b0;
        while (!done && n < 20) begin
            if (busy) b++;
            tick();
            n++;
        end
        chk("latency", 32'(n), 32'd4);
        chk("busy_cycles", 32'(b), 32'd4);
        chk("busy_with_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic chk_res(input string name, input logic [31:0] s, input logic [31:0] co, input logic ov);
        chk({name, "_sum"}, sum, s);
        chk({name, "_cout"}, cout, co);
        chk({name, "_ovf"}, {31'd0, overflow}, {31'd0, ov});
    endtask

    initial begin
        vec_t        tbl[6];
        logic [31:0] es, ec, ac;
        logic        eo;
        int          nd;
        add_rst_n = 1'b0; start = 1'b0; cin = 1'b0; clr_acc = 1'b0;
        inputX = 32'd0; inputY = 32'd0;
        tick(); tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk_res("rst", 32'd0, 32'd0, 1'b0);
        add_rst_n = 1'b1;
        tick();
`ifdef ADD_ACCUM_EN
        clr_acc = 1'b1; tick(); clr_acc = 1'b0;
        run_op(32'd10, 32'd999, 1'b0); chk("acc_10", sum, 32'd10);
        run_op(32'd20, 32'd999, 1'b0); chk("acc_30", sum, 32'd30);
        run_op(32'd30, 32'd999, 1'b0); chk("acc_60", sum, 32'd60);
        clr_acc = 1'b1; tick(); clr_acc = 1'b0;
        run_op(32'd5, 32'd999, 1'b0); chk("acc_5", sum, 32'd5);
        ac = 32'd5;
        tick();
        for (int i = 0; i < 30; i++) begin
            logic [31:0] rx;
            logic        rc;
            rx = $urandom; rc = 1'($urandom);
            ref_add(rx, ac, rc, es, ec, eo);
            run_op(rx, $urandom, rc);
            chk_res("rand_acc", es, ec, eo);
            ac = es;
        end
`else
        tbl[0] = '{32'd50, 32'd13, 1'b0, 32'd63, 32'h0, 1'b0};
        tbl[1] = '{32'd103, 32'd86, 1'b0, 32'd189, 32'h46, 1'b0};
        tbl[2] = '{32'hFFFFFFFF, 32'd1, 1'b0, 32'h0, 32'hFFFFFFFF, 1'b0};
        tbl[3] = '{32'h7FFFFFFF, 32'd1, 1'b0, 32'h80000000, 32'h7FFFFFFF, 1'b1};
        tbl[4] = '{32'h80000000, 32'h80000000, 1'b0, 32'h0, 32'h80000000, 1'b1};
        tbl[5] = '{32'hFFFFFFFF, 32'd0, 1'b1, 32'h0, 32'hFFFFFFFF, 1'b0};
        foreach (tbl[i]) begin
            run_op(tbl[i].x, tbl[i].y, tbl[i].c);
            chk_res("vec", tbl[i].s, tbl[i].co, tbl[i].ov);
            tick();
        end
        // start held high: results at E4 and E9
        inputX = 32'd103; inputY = 32'd86; cin = 1'b0; start = 1'b1;
        tick();
        inputX = 32'd86; inputY = 32'd100; cin = 1'b1;
        tick(); tick(); tick();
        chk("b2b_no_early_done", {31'd0, done}, 32'd0);
        tick();
        chk("b2b_done1", {31'd0, done}, 32'd1);
        chk("b2b_sum1", sum, 32'd189);
        tick();
        chk("b2b_busy2", {31'd0, busy}, 32'd1);
        chk("b2b_done_pulse", {31'd0, done}, 32'd0);
        tick(); tick(); tick(); tick();
        chk("b2b_done2", {31'd0, done}, 32'd1);
        chk("b2b_sum2", sum, 32'd187);
        start = 1'b0;
        tick(); tick();
        // start during CALC must be ignored
        inputX = 32'd1000; inputY = 32'd234; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        inputX = 32'd5; inputY = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        nd = 0;
        for (int i = 0; i < 3 && !done; i++) tick();
        chk("ign_done", {31'd0, done}, 32'd1);
        chk("ign_sum", sum, 32'd1234);
        for (int i = 0; i < 7; i++) begin
            tick();
            if (done) nd++;
        end
        chk("ign_no_second_done", 32'(nd), 32'd0);
        chk("ign_sum_held", sum, 32'd1234);
        // reset during CALC aborts the operation
        inputX = 32'hDEADBEEF; inputY = 32'h12345678; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        add_rst_n = 1'b0;
        tick();
        add_rst_n = 1'b1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk_res("abort", 32'd0, 32'd0, 1'b0);
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done || busy) nd++;
        end
        chk("abort_no_done", 32'(nd), 32'd0);
        for (int i = 0; i < 30; i++) begin
            logic [31:0] rx, ry;
            logic        rc;
            rx = $urandom; ry = $urandom; rc = 1'($urandom);
            if (i % 5 == 0) ry = ~rx;
            ref_add(rx, ry, rc, es, ec, eo);
            run_op(rx, ry, rc);
            chk_res("rand", es, ec, eo);
        end
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
